// File: rtl/load_store_unit.sv
// Load/store unit bridging CPU byte/halfword/word requests onto a word-wide, big-endian data memory.
// Sub-word stores use read-modify-write. Define LSU_RANGE_CHECK_EN to enable the MEM_BYTES range check.
module load_store_unit #(
  parameter int MEM_BYTES = 60
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Req,
  input  logic        ReqWrite,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] RData,
  output logic        AlignErr,
  output logic        RangeErr,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] MemRData
);

  localparam int DATA_W = 32;

`ifdef LSU_RANGE_CHECK_EN
  localparam logic RangeChkOn = 1'b1;
`else
  localparam logic RangeChkOn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} lsuState_e;

  lsuState_e             state, stateNext;
  logic                  isWrite_p0;
  logic [1:0]            size_p0;
  logic                  uns_p0;
  logic [1:0]            off_p0;
  logic [DATA_W-1:0]     wdata_p0;
  logic                  alignErr_p0;
  logic                  rangeErr_p0;
  logic                  accept;
  logic                  misaligned;
  logic                  rangeHit;

  // Lane 0 is the most significant byte of the memory word.
  function automatic logic [DATA_W-1:0] loadExtend(input logic [DATA_W-1:0] word,
                                                   input logic [1:0] size,
                                                   input logic [1:0] off,
                                                   input logic uns);
    logic signed [7:0]  lane8;
    logic signed [15:0] lane16;
    logic [DATA_W-1:0]  res;
    case (off)
      2'd0:    lane8 = word[31:24];
      2'd1:    lane8 = word[23:16];
      2'd2:    lane8 = word[15:8];
      default: lane8 = word[7:0];
    endcase
    lane16 = off[1] ? word[15:0] : word[31:16];
    if (size[1])
      res = word;
    else if (size[0])
      res = uns ? {16'b0, lane16} : {{16{lane16[15]}}, lane16};
    else
      res = uns ? {24'b0, lane8} : {{24{lane8[7]}}, lane8};
    return res;
  endfunction

  function automatic logic [DATA_W-1:0] storeMerge(input logic [DATA_W-1:0] word,
                                                   input logic [DATA_W-1:0] wd,
                                                   input logic [1:0] size,
                                                   input logic [1:0] off);
    logic [DATA_W-1:0] res;
    res = word;
    if (size[1])
      res = wd;
    else if (size[0]) begin
      if (off[1])
        res[15:0] = wd[15:0];
      else
        res[31:16] = wd[15:0];
    end else begin
      case (off)
        2'd0:    res[31:24] = wd[7:0];
        2'd1:    res[23:16] = wd[7:0];
        2'd2:    res[15:8]  = wd[7:0];
        default: res[7:0]   = wd[7:0];
      endcase
    end
    return res;
  endfunction

  // Last byte is computed one bit wider so addresses near 2^32 cannot wrap into range.
  function automatic logic outOfRange(input logic [31:0] a, input logic [1:0] size);
    logic [32:0] span;
    logic [32:0] lastByte;
    span     = size[1] ? 33'd3 : (size[0] ? 33'd1 : 33'd0);
    lastByte = {1'b0, a} + span;
    return ({1'b0, a} >= 33'(MEM_BYTES)) || (lastByte >= 33'(MEM_BYTES));
  endfunction

  assign accept = (state == IDLE) && Req;

  always_comb begin
    misaligned = 1'b0;
    if (Size[1])
      misaligned = |Addr[1:0];
    else if (Size[0])
      misaligned = Addr[0];
  end

  assign rangeHit = RangeChkOn && !misaligned && outOfRange(Addr, Size);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (Req) begin
          if (misaligned || rangeHit)
            stateNext = DONE;
          else if (ReqWrite && Size[1])
            stateNext = WRITE;
          else
            stateNext = READ;
        end
      end
      READ:    stateNext = isWrite_p0 ? WRITE : DONE;
      WRITE:   stateNext = DONE;
      default: stateNext = IDLE;
    endcase
  end

  // Stage p0: request capture at the accepting edge
  always_ff @(posedge CLK) begin
    if (accept) begin
      isWrite_p0 <= ReqWrite;
      size_p0    <= Size;
      uns_p0     <= Unsigned;
      off_p0     <= Addr[1:0];
      wdata_p0   <= WData;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      alignErr_p0 <= 1'b0;
      rangeErr_p0 <= 1'b0;
      RData       <= '0;
      MemAddr     <= '0;
      MemWData    <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        alignErr_p0 <= misaligned;
        rangeErr_p0 <= rangeHit;
        MemAddr     <= {Addr[31:2], 2'b00};
        if (ReqWrite)
          MemWData <= WData;
      end
      // Stage p1: read data consumed at the closing edge of READ
      if (state == READ) begin
        if (isWrite_p0)
          MemWData <= storeMerge(MemRData, wdata_p0, size_p0, off_p0);
        else
          RData <= loadExtend(MemRData, size_p0, off_p0, uns_p0);
      end
    end
  end

  // Strobes decode straight from state so an async reset releases them at once.
  assign Busy     = (state != IDLE);
  assign Done     = (state == DONE);
  assign MemRead  = (state != READ);
  assign MemWrite = (state != WRITE);
  assign AlignErr = Done && alignErr_p0;
  assign RangeErr = Done && rangeErr_p0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: behavioural big-endian memory, byte-level reference model and scoreboard.
module tb_load_store_unit;

  localparam int MEM_BYTES = 60;

  logic        clk = 1'b0;
  logic        RST;
  logic        Req, ReqWrite, Unsigned;
  logic [1:0]  Size;
  logic [31:0] Addr, WData;
  logic        Busy, Done, AlignErr, RangeErr, MemRead, MemWrite;
  logic [31:0] RData, MemAddr, MemWData, MemRData;

  logic [31:0] mem    [0:15];
  logic [7:0]  refMem [0:63];
  logic        preWe = 1'b0;
  logic [3:0]  preIdx;
  logic [31:0] preVal;

  logic [31:0] expRData = 32'd0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        aerr;
    logic        rerr;
    int          lat;
    int          reads;
    int          writes;
    string       tag;
  } expTxn_t;

  expTxn_t sbQ[$];

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .CLK(clk), .RST(RST), .Req(Req), .ReqWrite(ReqWrite), .Size(Size),
    .Unsigned(Unsigned), .Addr(Addr), .WData(WData), .Busy(Busy), .Done(Done),
    .RData(RData), .AlignErr(AlignErr), .RangeErr(RangeErr), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemRead(MemRead), .MemWrite(MemWrite), .MemRData(MemRData)
  );

  always #5 clk = ~clk;

  // Memory returns a junk pattern whenever it is not strobed.
  assign MemRData = MemRead ? 32'hA5A5_A5A5 : mem[MemAddr[5:2]];

  always @(negedge clk) begin
    if (preWe)
      mem[preIdx] <= preVal;
    else if (!MemWrite)
      mem[MemAddr[5:2]] <= MemWData;
  end

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] refWord(input int a);
    return {refMem[a], refMem[a+1], refMem[a+2], refMem[a+3]};
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    int ai;
    logic [7:0]  b;
    logic [15:0] h;
    ai = int'(a[5:0]);
    b  = refMem[ai];
    if (sz[1]) return refWord(ai);
    if (sz[0]) begin
      h = {refMem[ai], refMem[ai+1]};
      return uns ? {16'h0, h} : {{16{h[15]}}, h};
    end
    return uns ? {24'h0, b} : {{24{b[7]}}, b};
  endfunction

  task automatic refStore(input logic [31:0] a, input int nb, input logic [31:0] wd);
    for (int i = 0; i < nb; i++)
      refMem[int'(a[5:0]) + i] = 8'(wd >> (8 * (nb - 1 - i)));
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    preIdx = 4'(idx);
    preVal = val;
    preWe  = 1'b1;
    @(negedge clk);
    #1 preWe = 1'b0;
    for (int i = 0; i < 4; i++)
      refMem[idx*4 + i] = 8'(val >> (8 * (3 - i)));
  endtask

  task automatic checkResetVals(input string pfx);
    checkEq({pfx, ".busy"},     32'(Busy),     32'd0);
    checkEq({pfx, ".done"},     32'(Done),     32'd0);
    checkEq({pfx, ".alignerr"}, 32'(AlignErr), 32'd0);
    checkEq({pfx, ".rangeerr"}, 32'(RangeErr), 32'd0);
    checkEq({pfx, ".memread"},  32'(MemRead),  32'd1);
    checkEq({pfx, ".memwrite"}, 32'(MemWrite), 32'd1);
    checkEq({pfx, ".rdata"},    RData,         32'd0);
    checkEq({pfx, ".memaddr"},  MemAddr,       32'd0);
    checkEq({pfx, ".memwdata"}, MemWData,      32'd0);
  endtask

  task automatic doReq(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    expTxn_t e;
    int      nb;
    logic    mis, rng, seen;
    @(negedge clk);
    nb  = sz[1] ? 4 : (sz[0] ? 2 : 1);
    mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
    rng = 1'b0;
`ifdef LSU_RANGE_CHECK_EN
    rng = !mis && ((int'(a) + nb - 1) >= MEM_BYTES);
`endif
    e.tag  = tag;
    e.aerr = mis;
    e.rerr = rng;
    if (mis || rng) begin
      e.lat = 1; e.reads = 0; e.writes = 0;
    end else if (!wr) begin
      e.lat = 2; e.reads = 1; e.writes = 0;
      expRData = refLoad(a, sz, uns);
    end else if (nb == 4) begin
      e.lat = 2; e.reads = 0; e.writes = 1;
      refStore(a, nb, wd);
    end else begin
      e.lat = 3; e.reads = 1; e.writes = 1;
      refStore(a, nb, wd);
    end
    e.rdata = expRData;
    sbQ.push_back(e);
    Req = 1'b1; ReqWrite = wr; Size = sz; Unsigned = uns; Addr = a; WData = wd;
    @(posedge clk);
    #1;
    Req = 1'b0; ReqWrite = 1'($urandom); Size = 2'($urandom); Unsigned = 1'($urandom);
    Addr = $urandom; WData = $urandom;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (Done) seen = 1'b1;
    end
    if (!seen) begin
      checkEq({tag, ".timeout"}, 32'd0, 32'd1);
      sbQ.delete();
    end
  endtask

  int   elapsed = 0, rdLow = 0, wrLow = 0;
  logic wasBusy = 1'b0;

  always @(negedge clk) begin
    expTxn_t e;
    if (Busy) begin
      if (!wasBusy) begin
        elapsed = 1; rdLow = 0; wrLow = 0;
      end else begin
        elapsed++;
      end
      if (!MemRead)  rdLow++;
      if (!MemWrite) wrLow++;
      if (!MemRead && !MemWrite)
        checkEq("strobe_overlap", 32'd1, 32'd0);
      if (Done) begin
        if (sbQ.size() == 0) begin
          checkEq("sb_empty", 32'd0, 32'd1);
        end else begin
          e = sbQ.pop_front();
          checkEq({e.tag, ".rdata"},    RData,          e.rdata);
          checkEq({e.tag, ".alignerr"}, 32'(AlignErr),  32'(e.aerr));
          checkEq({e.tag, ".rangeerr"}, 32'(RangeErr),  32'(e.rerr));
          checkEq({e.tag, ".latency"},  32'(elapsed),   32'(e.lat));
          checkEq({e.tag, ".reads"},    32'(rdLow),     32'(e.reads));
          checkEq({e.tag, ".writes"},   32'(wrLow),     32'(e.writes));
        end
      end
    end
    wasBusy = Busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; Req = 1'b0; ReqWrite = 1'b0; Size = 2'b00; Unsigned = 1'b0;
    Addr = 32'd0; WData = 32'd0; preIdx = 4'd0; preVal = 32'd0;
    repeat (3) @(negedge clk);
    checkResetVals("rst");
    RST = 1'b1;

    preload(0, 32'h80FF_7F01);
    preload(1, 32'h1122_3344);
    for (int i = 2; i < 16; i++)
      preload(i, {8'(i), 8'hC3, ~8'(i), 8'h5A});

    // Reset asserted while the write strobe is low must abort the commit.
    @(negedge clk);
    Req = 1'b1; ReqWrite = 1'b1; Size = 2'b10; Unsigned = 1'b0; Addr = 32'd12; WData = 32'h1234_5678;
    @(posedge clk);
    #1 Req = 1'b0;
    checkEq("midw.memwrite_low", 32'(MemWrite), 32'd0);
    #2 RST = 1'b0;
    #1 checkResetVals("midw");
    @(negedge clk);
    #1 checkEq("midw.mem3", mem[3], refWord(12));
    @(negedge clk);
    RST = 1'b1;
    expRData = 32'd0;

    doReq("sw8", 1'b1, 2'b10, 1'b0, 32'd8, 32'hDEAD_BEEF);
    doReq("lw8", 1'b0, 2'b10, 1'b0, 32'd8, 32'd0);
    doReq("sb6", 1'b1, 2'b00, 1'b0, 32'd6, 32'h1234_56AA);
    checkEq("sb6.mem1", mem[1], 32'h1122_AA44);
    doReq("lw4",  1'b0, 2'b10, 1'b0, 32'd4, 32'd0);
    doReq("lb0",  1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    doReq("lbu1", 1'b0, 2'b00, 1'b1, 32'd1, 32'd0);
    doReq("lh2",  1'b0, 2'b01, 1'b0, 32'd2, 32'd0);
    doReq("lhu0", 1'b0, 2'b01, 1'b1, 32'd0, 32'd0);
    doReq("lh0",  1'b0, 2'b01, 1'b0, 32'd0, 32'd0);
    doReq("lb3",  1'b0, 2'b00, 1'b0, 32'd3, 32'd0);
    doReq("sh14", 1'b1, 2'b01, 1'b0, 32'd14, 32'hFFFF_8001);
    doReq("lw12", 1'b0, 2'b10, 1'b0, 32'd12, 32'd0);
    doReq("sb1",  1'b1, 2'b00, 1'b0, 32'd1, 32'h0000_0055);
    doReq("lw0s3", 1'b0, 2'b11, 1'b0, 32'd0, 32'd0);
    doReq("lh3",  1'b0, 2'b01, 1'b0, 32'd3, 32'd0);
    doReq("sw2",  1'b1, 2'b10, 1'b0, 32'd2, 32'hCAFE_F00D);
    doReq("lw5",  1'b0, 2'b10, 1'b0, 32'd5, 32'd0);
    doReq("lw56", 1'b0, 2'b10, 1'b0, 32'd56, 32'd0);
    doReq("lw60", 1'b0, 2'b10, 1'b0, 32'd60, 32'd0);
    doReq("lb59", 1'b0, 2'b00, 1'b1, 32'd59, 32'd0);
    doReq("lh58", 1'b0, 2'b01, 1'b0, 32'd58, 32'd0);
    doReq("lw59", 1'b0, 2'b10, 1'b0, 32'd59, 32'd0);
    doReq("sh62", 1'b1, 2'b01, 1'b0, 32'd62, 32'h0000_BEEF);
    doReq("lw60b", 1'b0, 2'b10, 1'b0, 32'd60, 32'd0);

    repeat (2) @(negedge clk);
    checkEq("sb_drained", 32'(sbQ.size()), 32'd0);
    for (int w = 0; w < 16; w++)
      checkEq($sformatf("mem%0d", w), mem[w], refWord(w * 4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
